// File: rtl/enc8x3_pkg.sv
// enc8x3_pkg: shared constants, state type and small helpers for the
// encoder8x3_stream slice.
//   VEC_W       request vector width (8)
//   CODE_W      binary code width (3)
//   enc_state_t FSM state encoding {IDLE, EMIT}
//   rot_right   rotate a request vector right by a code amount
//   is_one_hot  true when exactly one bit of a vector is set
package enc8x3_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // Rotating right by sh puts bit sh of v at position 0, so a lowest-index
  // search on the result starts at sh and wraps from VEC_W-1 back to 0.
  function automatic logic [VEC_W-1:0] rot_right(input logic [VEC_W-1:0]  v,
                                                 input logic [CODE_W-1:0] sh);
    logic [2*VEC_W-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[VEC_W-1:0];
  endfunction

  function automatic logic is_one_hot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/encoder8x3_stream_encoder4x2.sv
// encoder4x2: combinational 4-to-2 priority encoder, lowest index wins.
//   req   in  4  request lines
//   code  out 2  index of the lowest set request (0 when none set)
//   valid out 1  any request bit set
module encoder4x2 (
  input  logic [3:0] req,
  output logic [1:0] code,
  output logic       valid
);

  always_comb begin
    code  = 2'd0;
    valid = 1'b1;
    if (req[0])      code = 2'd0;
    else if (req[1]) code = 2'd1;
    else if (req[2]) code = 2'd2;
    else if (req[3]) code = 2'd3;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/encoder8x3_stream.sv
// encoder8x3_stream: accepts an 8-bit request vector over valid/ready and
// streams out the 3-bit index of every set bit, one index per beat, marking
// the final beat of each vector with out_last.
//
// Build option: define ENC8X3_RR_EN for round-robin selection. A pointer
// holding (last emitted code + 1) mod 8 picks the first set bit at or above
// it, wrapping 7 -> 0, and persists across vectors. Without the macro the
// lowest set index is always emitted first.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  in_vec is valid
//   in_ready   out  1  block can accept a vector (IDLE only)
//   in_vec     in   8  request lines, bit i requests code i
//   out_valid  out  1  out_code is valid
//   out_ready  in   1  consumer accepts the beat
//   out_code   out  3  binary index of the selected set bit
//   out_last   out  1  current beat is the last index of this vector
//   zero_err   out  1  one-cycle pulse after an all-zero vector is accepted
//   dbg_state  out  1  current FSM state (0 = IDLE, 1 = EMIT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never waits on ready, and once out_valid is raised the
// beat (out_code/out_last) holds until it transfers. Neither ready input
// feeds any output combinationally; all outputs derive from registers
// (in_ready and out_valid are additionally forced low while rst_n is low).
module encoder8x3_stream
  import enc8x3_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VEC_W-1:0]    in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_last,
  output logic                zero_err,
  output logic                dbg_state
);

  enc_state_t        state_q, state_d;
  logic [VEC_W-1:0]  pend_q, pend_d;
  logic              zero_err_q, zero_err_d;

  logic [VEC_W-1:0]  scan_vec;
  logic [1:0]        lo_code, hi_code;
  logic              lo_valid, hi_valid;
  logic [CODE_W-1:0] scan_idx;
  logic [CODE_W-1:0] sel_code;
  logic [VEC_W-1:0]  sel_mask;
  logic              sel_last;
  logic              have_bit;

`ifdef ENC8X3_RR_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;

  // Search the pending vector starting at the pointer, then translate the
  // rotated index back to the absolute code.
  assign scan_vec = rot_right(pend_q, ptr_q);
  assign sel_code = scan_idx + ptr_q;
`else
  assign scan_vec = pend_q;
  assign sel_code = scan_idx;
`endif

  encoder4x2 u_enc_lo (
    .req   (scan_vec[3:0]),
    .code  (lo_code),
    .valid (lo_valid)
  );

  encoder4x2 u_enc_hi (
    .req   (scan_vec[7:4]),
    .code  (hi_code),
    .valid (hi_valid)
  );

  // Low nibble has priority; the MSB of the index says which nibble won.
  assign scan_idx = {~lo_valid, (lo_valid ? lo_code : hi_code)};
  assign have_bit = lo_valid | hi_valid;
  assign sel_mask = VEC_W'(1) << sel_code;
  assign sel_last = is_one_hot(pend_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      zero_err_q <= 1'b0;
`ifdef ENC8X3_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
`ifdef ENC8X3_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
`ifdef ENC8X3_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pend_d  = in_vec;
            state_d = EMIT;
          end else begin
            // All-zero vector is consumed and only reported.
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~sel_mask;
`ifdef ENC8X3_RR_EN
          ptr_d  = sel_code + CODE_W'(1);
`endif
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = rst_n & (state_q == IDLE);
    // In EMIT the pending register is never empty; have_bit keeps a stray
    // empty register from ever presenting a beat.
    out_valid = rst_n & (state_q == EMIT) & have_bit;
    out_code  = out_valid ? sel_code : '0;
    out_last  = out_valid & sel_last;
    zero_err  = zero_err_q;
    dbg_state = state_q;
  end

endmodule
